// File: rtl/wait_event_ctrl_tb_if.sv
// rtl/wait_event_ctrl_tb_if.sv - command/status bundle between scenario decoder and wait engine
//
// Purpose : groups the command inputs, the monitored probe bus and the status
//           outputs of the wait engine so they travel as one port.
// Signals : i_start/i_abort      start request / abort current wait
//           i_sel/i_mode         channel index / event mode (0 WTR,1 WTF,2 WTE,3 WTV,4 WTC)
//           i_value/i_timeout    WTV compare value / max wait cycles (0 = forever)
//           i_wait               packed monitored channels
//           o_busy               high while waiting
//           o_wait_done          one-cycle pulse, event seen
//           o_timeout            one-cycle pulse, timeout expired
//           o_error              one-cycle pulse, start rejected
//           o_elapsed            cycles spent waiting at done/timeout
// Modports: master drives commands (decoder side), slave is the wait engine.

interface wait_event_ctrl_tb_if #(
  parameter int WAIT_SIZE     = 5,
  parameter int WAIT_WIDTH    = 1,
  parameter int TIMEOUT_WIDTH = 32
);
  localparam int SEL_W = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1;

  logic                            i_start;
  logic                            i_abort;
  logic [SEL_W-1:0]                i_sel;
  logic [2:0]                      i_mode;
  logic [WAIT_WIDTH-1:0]           i_value;
  logic [TIMEOUT_WIDTH-1:0]        i_timeout;
  logic [WAIT_SIZE*WAIT_WIDTH-1:0] i_wait;
  logic                            o_busy;
  logic                            o_wait_done;
  logic                            o_timeout;
  logic                            o_error;
  logic [TIMEOUT_WIDTH-1:0]        o_elapsed;

  modport master (
    output i_start, i_abort, i_sel, i_mode, i_value, i_timeout, i_wait,
    input  o_busy, o_wait_done, o_timeout, o_error, o_elapsed
  );

  modport slave (
    input  i_start, i_abort, i_sel, i_mode, i_value, i_timeout, i_wait,
    output o_busy, o_wait_done, o_timeout, o_error, o_elapsed
  );
endinterface

// File: rtl/wait_event_ctrl_tb.sv
// rtl/wait_event_ctrl_tb.sv - wait engine: arm on one probe channel, wait for an event or timeout
//
// Purpose : on a start request, latches channel/mode/value/timeout and waits for
//           the selected event on that channel (rise, fall, any edge, value match,
//           any change). Ends with a done pulse, a timeout pulse, or silently on
//           abort. Reports the number of cycles spent waiting.
// Ports   : clk    clock, rising edge
//           rst_n  asynchronous active-low reset
//           bus    wait_event_ctrl_tb_if.slave (commands, probe bus, status)

module wait_event_ctrl_tb #(
  parameter int WAIT_SIZE     = 5,
  parameter int WAIT_WIDTH    = 1,
  parameter int TIMEOUT_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  wait_event_ctrl_tb_if.slave  bus
);

  localparam int SEL_W = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1;
  localparam int BUS_W = WAIT_SIZE * WAIT_WIDTH;

  localparam logic [2:0] MODE_WTR = 3'd0;
  localparam logic [2:0] MODE_WTF = 3'd1;
  localparam logic [2:0] MODE_WTE = 3'd2;
  localparam logic [2:0] MODE_WTV = 3'd3;
  localparam logic [2:0] MODE_WTC = 3'd4;

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE  = TIMEOUT_WIDTH'(1);
  localparam logic [SEL_W:0]           SEL_LIM  = (SEL_W+1)'(WAIT_SIZE);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;

  logic [BUS_W-1:0]           r_s_wait;
  logic [SEL_W-1:0]           r_sel;
  logic [2:0]                 r_mode;
  logic [WAIT_WIDTH-1:0]      r_value;
  logic [TIMEOUT_WIDTH-1:0]   r_timeout;
  logic [TIMEOUT_WIDTH-1:0]   r_cnt;
  logic [TIMEOUT_WIDTH-1:0]   r_elapsed;
  logic                       r_done;
  logic                       r_to;
  logic                       r_err;

  logic [SEL_W-1:0]           w_sel_nxt;
  logic [2:0]                 w_mode_nxt;
  logic [WAIT_WIDTH-1:0]      w_value_nxt;
  logic [TIMEOUT_WIDTH-1:0]   w_timeout_nxt;
  logic [TIMEOUT_WIDTH-1:0]   w_cnt_nxt;
  logic [TIMEOUT_WIDTH-1:0]   w_elapsed_nxt;
  logic                       w_done_nxt;
  logic                       w_to_nxt;
  logic                       w_err_nxt;

  logic [WAIT_WIDTH-1:0]      w_cur;
  logic [WAIT_WIDTH-1:0]      w_prev;
  logic                       w_event;
  logic                       w_cmd_ok;
  logic [TIMEOUT_WIDTH-1:0]   w_cnt_inc;

  // Channel pick uses an explicit compare per channel so an out-of-range
  // latched index can never produce an out-of-bounds part select.
  always_comb begin
    w_cur  = '0;
    w_prev = '0;
    for (int j = 0; j < WAIT_SIZE; j++) begin
      if (r_sel == SEL_W'(j)) begin
        w_cur  = bus.i_wait[j*WAIT_WIDTH +: WAIT_WIDTH];
        w_prev = r_s_wait[j*WAIT_WIDTH +: WAIT_WIDTH];
      end
    end
  end

  // Edge modes look at bit 0 only; value and change modes use the full channel.
  always_comb begin
    w_event = 1'b0;
    case (r_mode)
      MODE_WTR: w_event = ~w_prev[0] &  w_cur[0];
      MODE_WTF: w_event =  w_prev[0] & ~w_cur[0];
      MODE_WTE: w_event =  w_prev[0] ^  w_cur[0];
      MODE_WTV: w_event = (w_cur == r_value);
      MODE_WTC: w_event = (w_cur != w_prev);
      default:  w_event = 1'b0;
    endcase
  end

  // The extra sel bit keeps the range check correct when WAIT_SIZE is a power of two.
  assign w_cmd_ok  = ({1'b0, bus.i_sel} < SEL_LIM) && (bus.i_mode <= MODE_WTC);

  // Saturating increment: a forever wait parks at all-ones instead of wrapping.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_mode_nxt    = r_mode;
    w_value_nxt   = r_value;
    w_timeout_nxt = r_timeout;
    w_cnt_nxt     = r_cnt;
    w_elapsed_nxt = r_elapsed;
    w_done_nxt    = 1'b0;
    w_to_nxt      = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (w_cmd_ok) begin
            w_sel_nxt     = bus.i_sel;
            w_mode_nxt    = bus.i_mode;
            w_value_nxt   = bus.i_value;
            w_timeout_nxt = bus.i_timeout;
            w_cnt_nxt     = '0;
            w_elapsed_nxt = '0;
            w_state_nxt   = ST_WAIT;
          end else begin
            w_err_nxt     = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Abort beats event beats timeout, so an event on the expiry cycle reports done.
        if (bus.i_abort) begin
          w_state_nxt   = ST_IDLE;
        end else if (w_event) begin
          w_done_nxt    = 1'b1;
          w_elapsed_nxt = w_cnt_inc;
          w_state_nxt   = ST_IDLE;
        end else if ((r_timeout != '0) && (w_cnt_inc == r_timeout)) begin
          w_to_nxt      = 1'b1;
          w_elapsed_nxt = r_timeout;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_cnt_nxt     = w_cnt_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_s_wait  <= '0;
      r_sel     <= '0;
      r_mode    <= '0;
      r_value   <= '0;
      r_timeout <= '0;
      r_cnt     <= '0;
      r_elapsed <= '0;
      r_done    <= 1'b0;
      r_to      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_s_wait  <= bus.i_wait;
      r_sel     <= w_sel_nxt;
      r_mode    <= w_mode_nxt;
      r_value   <= w_value_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
      r_elapsed <= w_elapsed_nxt;
      r_done    <= w_done_nxt;
      r_to      <= w_to_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign bus.o_busy      = (r_state == ST_WAIT);
  assign bus.o_wait_done = r_done;
  assign bus.o_timeout   = r_to;
  assign bus.o_error     = r_err;
  assign bus.o_elapsed   = r_elapsed;

endmodule
